// File: rtl/uart_tx_fifo.sv
// UART transmitter with a power-of-two character FIFO and configurable frame (data bits, parity, stop bits).
// Queued characters go out back-to-back: the next frame is loaded on the last clock of the previous stop bit.
module uart_tx_fifo #(
  parameter int CLK_RATE   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic [DATA_BITS-1:0]              TxData,
  input  logic                              TxValid,
  output logic                              TxReady,
  output logic                              Tx,
  output logic                              TxBusy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   FifoCount
);

  localparam int DIV = (CLK_RATE + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int NW  = $clog2(FIFO_DEPTH + 1);
  localparam int IW  = $clog2(DATA_BITS);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DIV < 2) begin : g_param_check
      $error("uart_tx_fifo: illegal parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic                 stop_idx, stop_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par, par_nxt;
  logic                 tx_q, tx_nxt;
  logic                 busy_q, busy_nxt;
  logic                 bit_end, load;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [NW-1:0]        count;
  logic [DATA_BITS-1:0] rd_dat;
  logic                 push, pop;

  assign TxReady   = (count < NW'(FIFO_DEPTH));
  assign FifoCount = count;
  assign Tx        = tx_q;
  assign TxBusy    = busy_q;
  assign push      = TxValid && TxReady;
  assign rd_dat    = mem[rd_ptr];
  assign bit_end   = (cnt == CW'(DIV - 1));

  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr] <= TxData;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    stop_nxt  = stop_idx;
    shreg_nxt = shreg;
    par_nxt   = par;
    tx_nxt    = tx_q;
    pop       = 1'b0;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        tx_nxt  = 1'b1;
        cnt_nxt = '0;
        load    = (count != '0);
      end
      S_START: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          tx_nxt    = shreg[0];
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (idx == IW'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              tx_nxt    = par;
              state_nxt = S_PARITY;
            end else begin
              tx_nxt    = 1'b1;
              stop_nxt  = 1'b0;
              state_nxt = S_STOP;
            end
          end else begin
            // Shift so the next bit always sits at position 0.
            idx_nxt   = idx + IW'(1);
            tx_nxt    = shreg[1];
            shreg_nxt = shreg >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          tx_nxt    = 1'b1;
          stop_nxt  = 1'b0;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (stop_idx == 1'(STOP_BITS - 1)) begin
            load      = (count != '0);
            tx_nxt    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            stop_nxt = 1'b1;
          end
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
    // Parity is taken from the popped character, so later FIFO writes cannot disturb it.
    if (load) begin
      pop       = 1'b1;
      shreg_nxt = rd_dat;
      par_nxt   = (PARITY == 2) ? ^rd_dat : ~^rd_dat;
      tx_nxt    = 1'b0;
      cnt_nxt   = '0;
      state_nxt = S_START;
    end
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par      <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      stop_idx <= stop_nxt;
      shreg    <= shreg_nxt;
      par      <= par_nxt;
      tx_q     <= tx_nxt;
      busy_q   <= busy_nxt;
    end
  end

endmodule
